ifu_axil_rd_slave: RTL

- AXI-lite read-channel responder that serves the instruction fetch unit's ar/r interface from a synchronous instruction SRAM.
- Accepts up to REQ_DEPTH outstanding read addresses and returns 64-bit doublewords strictly in request order.
- Out-of-range addresses get a DECERR response.
- Optional per-request wait cycles emulate slow memory, so IFU backpressure and outstanding-count logic can be stressed.

---
 rtl/ifu_axil_rd_slave_if.sv | 15 +
 rtl/ifu_axil_rd_slave.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ifu_axil_rd_slave_if.sv
// rtl/ifu_axil_rd_slave_if.sv - IFU AXI-lite read channel (ar/r) bundle
interface ifu_axil_rd_slave_if;
  logic        arvalid;
  logic        arready;
  logic [63:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [63:0] rdata;

  modport master (output arvalid, araddr, rready,
                  input  arready, rvalid, rresp, rdata);
  modport slave  (input  arvalid, araddr, rready,
                  output arready, rvalid, rresp, rdata);
endinterface

// File: rtl/ifu_axil_rd_slave.sv
// rtl/ifu_axil_rd_slave.sv - AXI-lite read responder serving IFU fetches from a synchronous SRAM
// Requests are queued, issued in order with optional wait cycles, and answered strictly in order.
module ifu_axil_rd_slave #(
  parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
  parameter int          MEM_AW         = 16,
  parameter int          REQ_DEPTH_LOG2 = 2,
  parameter int          WAIT_CYCLES    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  ifu_axil_rd_slave_if.slave ifu,
  output logic               sram_en,
  output logic [MEM_AW-1:0]  sram_addr,
  input  logic [63:0]        sram_rdata
);
  localparam int REQ_DEPTH = 1 << REQ_DEPTH_LOG2;
  localparam int CW        = REQ_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ} state_t;

  logic [MEM_AW-1:0]         r_req_idx [REQ_DEPTH];
  logic [REQ_DEPTH-1:0]      r_req_err;
  logic [REQ_DEPTH_LOG2-1:0] r_req_wp, r_req_rp;
  logic [CW-1:0]             r_req_cnt;

  logic [63:0] r_rsp_data [2];
  logic [1:0]  r_rsp_resp [2];
  logic        r_rsp_wp, r_rsp_rp;
  logic [1:0]  r_rsp_cnt;
  logic        r_inflight;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_do_read;

  logic [60:0]       w_word;
  logic              w_err;
  logic              w_req_push, w_req_empty;
  logic [MEM_AW-1:0] w_head_idx;
  logic              w_head_err;
  logic              w_credit, w_can_read;
  logic              w_r_pop, w_rsp_pop, w_push_rd, w_push_err, w_rsp_push;
  logic [63:0]       w_push_data;
  logic [1:0]        w_push_resp;

  // Decode on doubleword granularity; BASE_ADDR is doubleword aligned.
  assign w_word      = ifu.araddr[63:3] - BASE_ADDR[63:3];
  assign w_err       = (ifu.araddr < BASE_ADDR) | (|w_word[60:MEM_AW]);
  assign ifu.arready = ~r_req_cnt[CW-1];
  assign w_req_push  = ifu.arvalid & ifu.arready;
  assign w_req_empty = (r_req_cnt == '0);
  assign w_head_idx  = r_req_idx[r_req_rp];
  assign w_head_err  = r_req_err[r_req_rp];

  // An error entry waits for any older SRAM read to land so ordering holds.
  assign w_credit   = ({1'b0, r_rsp_cnt} + {2'b00, r_inflight}) < 3'd2;
  assign w_can_read = ~w_req_empty & w_credit & ~(w_head_err & r_inflight);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_do_read   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (WAIT_CYCLES == 0) begin
          w_do_read = w_can_read;
        end else if (~w_req_empty & w_credit) begin
          w_state_nxt = (WAIT_CYCLES > 1) ? S_WAIT : S_READ;
          w_cnt_nxt   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd2) w_state_nxt = S_READ;
      end
      S_READ: begin
        if (w_can_read) begin
          w_do_read = 1'b1;
          if (r_req_cnt > CW'(1)) begin
            w_state_nxt = (WAIT_CYCLES > 1) ? S_WAIT : S_READ;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sram_en   = w_do_read & ~w_head_err;
  assign sram_addr = w_head_idx;

  // The in-flight read is the youngest response; it is shown directly when the buffer is empty.
  assign ifu.rvalid = (r_rsp_cnt != 2'd0) | r_inflight;
  always_comb begin
    ifu.rdata = 64'd0;
    ifu.rresp = 2'b00;
    if (r_rsp_cnt != 2'd0) begin
      ifu.rdata = r_rsp_data[r_rsp_rp];
      ifu.rresp = r_rsp_resp[r_rsp_rp];
    end else if (r_inflight) begin
      ifu.rdata = sram_rdata;
    end
  end

  assign w_r_pop     = ifu.rvalid & ifu.rready;
  assign w_rsp_pop   = w_r_pop & (r_rsp_cnt != 2'd0);
  assign w_push_rd   = r_inflight & ~(w_r_pop & (r_rsp_cnt == 2'd0));
  assign w_push_err  = w_do_read & w_head_err;
  assign w_rsp_push  = w_push_rd | w_push_err;
  assign w_push_data = w_push_err ? 64'd0 : sram_rdata;
  assign w_push_resp = w_push_err ? 2'b11 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_req_wp   <= '0;
      r_req_rp   <= '0;
      r_req_cnt  <= '0;
      r_rsp_wp   <= 1'b0;
      r_rsp_rp   <= 1'b0;
      r_rsp_cnt  <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_inflight <= w_do_read & ~w_head_err;
      if (w_req_push) r_req_wp <= r_req_wp + 1'b1;
      if (w_do_read)  r_req_rp <= r_req_rp + 1'b1;
      r_req_cnt <= r_req_cnt + CW'(w_req_push) - CW'(w_do_read);
      if (w_rsp_push) r_rsp_wp <= ~r_rsp_wp;
      if (w_rsp_pop)  r_rsp_rp <= ~r_rsp_rp;
      r_rsp_cnt <= r_rsp_cnt + {1'b0, w_rsp_push} - {1'b0, w_rsp_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_push) begin
      r_req_idx[r_req_wp] <= w_word[MEM_AW-1:0];
      r_req_err[r_req_wp] <= w_err;
    end
    if (w_rsp_push) begin
      r_rsp_data[r_rsp_wp] <= w_push_data;
      r_rsp_resp[r_rsp_wp] <= w_push_resp;
    end
  end
endmodule
